fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu16_pkg.sv | 29 ++
 rtl/fetch_skid_buf.sv | 32 +++
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit core: data width, fetch FSM states,
// instruction-word and fetch-packet types.
package cpu16_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] instr_t;
  typedef logic [XLEN-1:0] addr_t;

  // IDLE: no request; WAIT: request outstanding, result kept;
  // DRAIN: request outstanding, result thrown away after a redirect.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } fetch_pkt_t;

  // Sequential PC advance; the addition wraps modulo 2^XLEN.
  function automatic addr_t pc_add(input addr_t a, input addr_t step);
    return a + step;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry pc/instr holding register that catches a fetched word when the
// output stage is stalled. Flush beats load, load beats unload, so a
// simultaneous unload+load leaves the entry full with the new word.
module fetch_skid_buf
  import cpu16_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       unload,
  input  logic       flush,
  input  fetch_pkt_t din,
  output logic       valid,
  output fetch_pkt_t dout
);

  // Entry occupancy and payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one outstanding read at a time, delivers
// words in order to the IF/ID register, absorbs one word of stall slack in
// a skid entry, and flushes on redirect (discarding an in-flight read).
// Optional macro FETCH_PERF_CNT_EN adds fetch_count / flush_count outputs.
module fetch_unit
  import cpu16_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000,
  parameter logic [XLEN-1:0] PC_STEP  = 16'd1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]     fetch_count,
  output logic [15:0]     flush_count
`endif
);

  fetch_state_e state, state_n;
  addr_t        pc, pc_n, addr_n, ifpc_n;
  instr_t       ifins_n;
  logic         req_n, ifv_n;
  logic         consume, ack_v, slot_free;
  logic         sk_valid, sk_load, sk_unload, sk_flush, sk_after;
  fetch_pkt_t   sk_din, sk_dout;

  // Output leaves this cycle; ack only counts against a live request.
  assign consume   = if_valid & ~stall;
  assign ack_v     = imem_ack & imem_req;
  // A new request may only go out if its result is guaranteed a home.
  assign slot_free = ~sk_valid & ~(if_valid & stall);
  assign sk_din    = '{pc: imem_addr, instr: imem_rdata};

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst    (rst),
    .load   (sk_load),
    .unload (sk_unload),
    .flush  (sk_flush),
    .din    (sk_din),
    .valid  (sk_valid),
    .dout   (sk_dout)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state, request, pc, output stage and skid controls.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    req_n     = imem_req;
    addr_n    = imem_addr;
    ifv_n     = if_valid;
    ifpc_n    = if_pc;
    ifins_n   = if_instr;
    sk_load   = 1'b0;
    sk_unload = 1'b0;
    sk_flush  = 1'b0;
    sk_after  = sk_valid;
    if (redirect) begin
      // Flush everything; an un-acked request must still complete, so
      // keep it on the bus and drop its data later in DRAIN.
      pc_n     = redirect_pc;
      ifv_n    = 1'b0;
      sk_flush = 1'b1;
      if (state != S_IDLE && !ack_v) begin
        state_n = S_DRAIN;
      end else begin
        state_n = S_IDLE;
        req_n   = 1'b0;
      end
    end else begin
      // Refill the output from the skid entry, or empty it.
      if (consume && sk_valid) begin
        ifv_n     = 1'b1;
        ifpc_n    = sk_dout.pc;
        ifins_n   = sk_dout.instr;
        sk_unload = 1'b1;
        sk_after  = 1'b0;
      end else if (consume) begin
        ifv_n = 1'b0;
      end
      unique case (state)
        S_IDLE: begin
          if (slot_free) begin
            state_n = S_WAIT;
            req_n   = 1'b1;
            addr_n  = pc;
          end
        end
        S_WAIT: begin
          if (ack_v) begin
            pc_n = pc_add(imem_addr, PC_STEP);
            if ((!if_valid || consume) && !sk_unload) begin
              ifv_n   = 1'b1;
              ifpc_n  = imem_addr;
              ifins_n = imem_rdata;
            end else begin
              sk_load  = 1'b1;
              sk_after = 1'b1;
            end
            // Back-to-back issue keeps one instruction per cycle.
            if (!sk_after && !(ifv_n && stall)) begin
              state_n = S_WAIT;
              req_n   = 1'b1;
              addr_n  = pc_n;
            end else begin
              state_n = S_IDLE;
              req_n   = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (ack_v) begin
            state_n = S_IDLE;
            req_n   = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Registered pc, memory request and output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      if_valid  <= 1'b0;
      if_pc     <= '0;
      if_instr  <= '0;
    end else begin
      pc        <= pc_n;
      imem_req  <= req_n;
      imem_addr <= addr_n;
      if_valid  <= ifv_n;
      if_pc     <= ifpc_n;
      if_instr  <= ifins_n;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Consumption and flush event counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      if (consume)  fetch_count <= fetch_count + 16'd1;
      if (redirect) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule
